// File: rtl/sccpu_pkg.sv
// ---------------------------------------------------------------------------
// sccpu_pkg
// Shared definitions for the single-cycle MIPS-subset core: opcode and funct
// encodings, the ALU operation set, write-back source selection, the reset
// PC and the memory-mapped I/O addresses that live in data memory.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package sccpu_pkg;

    // Core-level constants
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          RF_DEPTH = 32;

    // Memory-mapped I/O locations inside data memory
    localparam logic [31:0] IO_IN1_ADDR  = 32'h0000_0000;
    localparam logic [31:0] IO_IN2_ADDR  = 32'h0000_0004;
    localparam logic [31:0] IO_OUT1_ADDR = 32'h0000_0008;
    localparam logic [31:0] IO_OUT2_ADDR = 32'h0000_000C;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (inst[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU operations
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI
    } alu_op_t;

    // Source of the register write-back value
    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_LINK
    } wb_sel_t;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/sccpu_alu.sv
// ---------------------------------------------------------------------------
// sccpu_alu
// Purely combinational 32-bit ALU for the single-cycle core.
// Ports:
//   a      in  32  first operand (rs value)
//   b      in  32  second operand (rt value or extended immediate)
//   shamt  in  5   shift amount for SLL/SRL/SRA
//   op     in  4   operation select (alu_op_t)
//   y      out 32  result
// Shifts operate on b; LUI places b[15:0] in the upper half.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sccpu_alu
    import sccpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_t     op,
    output logic [31:0] y
);

    always_comb begin
        y = 32'd0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'd0, a < b};
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
            ALU_SRA:  y = $unsigned($signed(b) >>> shamt);
            ALU_LUI:  y = {b[15:0], 16'h0000};
            default:  y = 32'd0;
        endcase
    end

endmodule

// File: rtl/sccpu_core.sv
// ---------------------------------------------------------------------------
// sccpu_core
// Single-cycle 32-bit MIPS-subset processor. One instruction retires on every
// rising edge of inclk; instruction and data memories are external.
// Ports:
//   inclk         in  1   CPU clock, rising-edge active
//   rstn          in  1   asynchronous active-low reset
//   inst          in  32  instruction word at PC
//   DM_rdata      in  32  data-memory read data (combinational)
//   IM_R          out 1   instruction-memory read enable, always 1
//   DM_CS         out 1   data-memory chip select (lw/sw)
//   DM_R          out 1   data-memory read strobe (lw)
//   DM_W          out 1   data-memory write strobe (sw)
//   PC            out 32  current program counter
//   ALU_out       out 32  ALU result of the current instruction
//   DM_addr       out 32  data-memory byte address (= ALU_out)
//   DM_wdata      out 32  data-memory write data (= rt value)
//   test_rf_addr  in  32  debug register index, bits [4:0] used
//   test_rf_data  out 32  combinational read of the debug register
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sccpu_core #(
    parameter logic [31:0] RESET_PC = sccpu_pkg::RESET_PC,
    parameter int          RF_DEPTH = sccpu_pkg::RF_DEPTH
) (
    input  logic        inclk,
    input  logic        rstn,
    input  logic [31:0] inst,
    input  logic [31:0] DM_rdata,
    output logic        IM_R,
    output logic        DM_CS,
    output logic        DM_R,
    output logic        DM_W,
    output logic [31:0] PC,
    output logic [31:0] ALU_out,
    output logic [31:0] DM_addr,
    output logic [31:0] DM_wdata,
    input  logic [31:0] test_rf_addr,
    output logic [31:0] test_rf_data
);
    import sccpu_pkg::*;

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt_field;
    logic [15:0] imm;

    assign opcode      = inst[31:26];
    assign rs          = inst[25:21];
    assign rt          = inst[20:16];
    assign rd          = inst[15:11];
    assign shamt_field = inst[10:6];
    assign funct       = inst[5:0];
    assign imm         = inst[15:0];

    // Program counter and register file state
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] rf [RF_DEPTH];
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  dbg_idx;

    // Decoder outputs
    alu_op_t     alu_op;
    wb_sel_t     wb_sel;
    logic        use_imm;
    logic        imm_zero_ext;
    logic        shift_var;
    logic        reg_write;
    logic [4:0]  wr_addr;
    logic        mem_read;
    logic        mem_write;
    logic        is_beq;
    logic        is_bne;
    logic        is_jump;
    logic        is_jr;

    // Datapath
    logic [31:0] imm_sext;
    logic [31:0] imm_ext;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_y;
    logic [31:0] wr_data;
    logic [31:0] branch_target;
    logic        rs_eq_rt;

    // Only the low five bits of the debug index select a register
    logic unused_dbg_bits;
    assign unused_dbg_bits = &{1'b0, test_rf_addr[31:5]};
    assign dbg_idx = test_rf_addr[4:0];

    // $0 is forced to read zero on every read port
    assign rs_val       = (rs == 5'd0)      ? 32'd0 : rf[rs];
    assign rt_val       = (rt == 5'd0)      ? 32'd0 : rf[rt];
    assign test_rf_data = (dbg_idx == 5'd0) ? 32'd0 : rf[dbg_idx];

    // Control decoder: unknown opcodes and functs fall through as NOPs
    always_comb begin
        alu_op       = ALU_ADD;
        wb_sel       = WB_ALU;
        use_imm      = 1'b0;
        imm_zero_ext = 1'b0;
        shift_var    = 1'b0;
        reg_write    = 1'b0;
        wr_addr      = rd;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        is_beq       = 1'b0;
        is_bne       = 1'b0;
        is_jump      = 1'b0;
        is_jr        = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    FN_SLLV: begin
                        alu_op    = ALU_SLL;
                        shift_var = 1'b1;
                    end
                    FN_SRLV: begin
                        alu_op    = ALU_SRL;
                        shift_var = 1'b1;
                    end
                    FN_SRAV: begin
                        alu_op    = ALU_SRA;
                        shift_var = 1'b1;
                    end
                    FN_JR: begin
                        reg_write = 1'b0;
                        is_jr     = 1'b1;
                    end
                    default: reg_write = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                use_imm   = 1'b1;
                reg_write = 1'b1;
                wr_addr   = rt;
            end
            OP_SLTI: begin
                alu_op    = ALU_SLT;
                use_imm   = 1'b1;
                reg_write = 1'b1;
                wr_addr   = rt;
            end
            OP_SLTIU: begin
                alu_op    = ALU_SLTU;
                use_imm   = 1'b1;
                reg_write = 1'b1;
                wr_addr   = rt;
            end
            OP_ANDI: begin
                alu_op       = ALU_AND;
                use_imm      = 1'b1;
                imm_zero_ext = 1'b1;
                reg_write    = 1'b1;
                wr_addr      = rt;
            end
            OP_ORI: begin
                alu_op       = ALU_OR;
                use_imm      = 1'b1;
                imm_zero_ext = 1'b1;
                reg_write    = 1'b1;
                wr_addr      = rt;
            end
            OP_XORI: begin
                alu_op       = ALU_XOR;
                use_imm      = 1'b1;
                imm_zero_ext = 1'b1;
                reg_write    = 1'b1;
                wr_addr      = rt;
            end
            OP_LUI: begin
                alu_op    = ALU_LUI;
                use_imm   = 1'b1;
                reg_write = 1'b1;
                wr_addr   = rt;
            end
            OP_LW: begin
                use_imm   = 1'b1;
                reg_write = 1'b1;
                wr_addr   = rt;
                wb_sel    = WB_MEM;
                mem_read  = 1'b1;
            end
            OP_SW: begin
                use_imm   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                alu_op = ALU_SUB;
                is_beq = 1'b1;
            end
            OP_BNE: begin
                alu_op = ALU_SUB;
                is_bne = 1'b1;
            end
            OP_J: is_jump = 1'b1;
            OP_JAL: begin
                is_jump   = 1'b1;
                reg_write = 1'b1;
                wr_addr   = 5'd31;
                wb_sel    = WB_LINK;
            end
            default: ;
        endcase
    end

    // Immediate extension and ALU operand selection
    assign imm_sext  = sext16(imm);
    assign imm_ext   = imm_zero_ext ? {16'h0000, imm} : imm_sext;
    assign alu_b     = use_imm ? imm_ext : rt_val;
    assign alu_shamt = shift_var ? rs_val[4:0] : shamt_field;

    sccpu_alu u_alu (
        .a     (rs_val),
        .b     (alu_b),
        .shamt (alu_shamt),
        .op    (alu_op),
        .y     (alu_y)
    );

    // Write-back value selection
    always_comb begin
        wr_data = alu_y;
        case (wb_sel)
            WB_ALU:  wr_data = alu_y;
            WB_MEM:  wr_data = DM_rdata;
            WB_LINK: wr_data = pc_plus4;
            default: wr_data = alu_y;
        endcase
    end

    // Next-PC selection; branch offsets are relative to PC+4
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign rs_eq_rt      = (rs_val == rt_val);

    always_comb begin
        pc_next = pc_plus4;
        if (is_jr) begin
            pc_next = rs_val;
        end else if (is_jump) begin
            pc_next = {pc_plus4[31:28], inst[25:0], 2'b00};
        end else if ((is_beq && rs_eq_rt) || (is_bne && !rs_eq_rt)) begin
            pc_next = branch_target;
        end
    end

    // PC register
    always_ff @(posedge inclk or negedge rstn) begin
        if (!rstn) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Register file write port; writes to $0 are dropped
    always_ff @(posedge inclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= 32'd0;
            end
        end else if (reg_write && (wr_addr != 5'd0)) begin
            rf[wr_addr] <= wr_data;
        end
    end

    // Outputs
    assign IM_R     = 1'b1;
    assign PC       = pc_q;
    assign ALU_out  = alu_y;
    assign DM_addr  = alu_y;
    assign DM_wdata = rt_val;
    assign DM_CS    = mem_read | mem_write;
    assign DM_R     = mem_read;
    assign DM_W     = mem_write;

endmodule

// File: tb/tb_sccpu_core.sv
// ---------------------------------------------------------------------------
// tb_sccpu_core
// Self-checking bench for sccpu_core. A behavioural model (register array and
// PC) executes each instruction with plain arithmetic; the DUT's outputs are
// compared before the edge (memory strobes, ALU result, no write-through) and
// after the edge (PC, written register).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sccpu_core;

    logic        inclk = 1'b0;
    logic        rstn  = 1'b0;
    logic [31:0] inst;
    logic [31:0] DM_rdata;
    logic        IM_R;
    logic        DM_CS;
    logic        DM_R;
    logic        DM_W;
    logic [31:0] PC;
    logic [31:0] ALU_out;
    logic [31:0] DM_addr;
    logic [31:0] DM_wdata;
    logic [31:0] test_rf_addr;
    logic [31:0] test_rf_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_pc;

    sccpu_core dut (
        .inclk        (inclk),
        .rstn         (rstn),
        .inst         (inst),
        .DM_rdata     (DM_rdata),
        .IM_R         (IM_R),
        .DM_CS        (DM_CS),
        .DM_R         (DM_R),
        .DM_W         (DM_W),
        .PC           (PC),
        .ALU_out      (ALU_out),
        .DM_addr      (DM_addr),
        .DM_wdata     (DM_wdata),
        .test_rf_addr (test_rf_addr),
        .test_rf_data (test_rf_data)
    );

    always #5 inclk = ~inclk;

    // Instruction encoders
    function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rs, input int rt,
                                          input int rd, input int sh);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                          input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_ins(input logic [5:0] op, input int target);
        return {op, 26'(target)};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
        test_rf_addr = ($urandom() & 32'hFFFF_FFE0) | 32'(idx);
        #1;
        check_output(tag, test_rf_data, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endtask

    // Reset state: PC at zero, every register (debug port) reads zero
    task automatic check_reset_state(input string tag);
        check_output({tag, "_pc"}, PC, 32'd0);
        check_output({tag, "_im_r"}, {31'd0, IM_R}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            check_reg($sformatf("%s_rf%0d", tag, i), i, 32'd0);
        end
    endtask

    // Drive one instruction, model it, check before and after its edge
    task automatic apply_stimulus(input logic [31:0] ins, input logic [31:0] rdata);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, dst;
        logic [31:0] a, b, simm, zimm, pc4, npc, val, addr;
        logic        we, cs, rstb, wstb, alu_chk;
        op   = ins[31:26];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        sh   = ins[10:6];
        fn   = ins[5:0];
        a    = m_rf[rs];
        b    = m_rf[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0000, ins[15:0]};
        pc4  = m_pc + 32'd4;
        npc  = pc4;
        we = 1'b0; cs = 1'b0; rstb = 1'b0; wstb = 1'b0; alu_chk = 1'b0;
        dst = rd; val = 32'd0; addr = 32'd0;
        case (op)
            6'h00: begin
                we = 1'b1; alu_chk = 1'b1;
                case (fn)
                    6'h20, 6'h21: val = a + b;
                    6'h22, 6'h23: val = a - b;
                    6'h24: val = a & b;
                    6'h25: val = a | b;
                    6'h26: val = a ^ b;
                    6'h27: val = ~(a | b);
                    6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: val = (a < b) ? 32'd1 : 32'd0;
                    6'h00: val = b << sh;
                    6'h02: val = b >> sh;
                    6'h03: val = $unsigned($signed(b) >>> sh);
                    6'h04: val = b << a[4:0];
                    6'h06: val = b >> a[4:0];
                    6'h07: val = $unsigned($signed(b) >>> a[4:0]);
                    6'h08: begin we = 1'b0; alu_chk = 1'b0; npc = a; end
                    default: begin we = 1'b0; alu_chk = 1'b0; end
                endcase
            end
            6'h08, 6'h09: begin we = 1'b1; alu_chk = 1'b1; dst = rt; val = a + simm; end
            6'h0A: begin we = 1'b1; alu_chk = 1'b1; dst = rt;
                         val = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; end
            6'h0B: begin we = 1'b1; alu_chk = 1'b1; dst = rt; val = (a < simm) ? 32'd1 : 32'd0; end
            6'h0C: begin we = 1'b1; alu_chk = 1'b1; dst = rt; val = a & zimm; end
            6'h0D: begin we = 1'b1; alu_chk = 1'b1; dst = rt; val = a | zimm; end
            6'h0E: begin we = 1'b1; alu_chk = 1'b1; dst = rt; val = a ^ zimm; end
            6'h0F: begin we = 1'b1; alu_chk = 1'b1; dst = rt; val = {ins[15:0], 16'h0000}; end
            6'h23: begin we = 1'b1; dst = rt; val = rdata; addr = a + simm; cs = 1'b1; rstb = 1'b1; end
            6'h2B: begin dst = rt; addr = a + simm; cs = 1'b1; wstb = 1'b1; end
            6'h04: if (a == b) npc = pc4 + (simm << 2);
            6'h05: if (a != b) npc = pc4 + (simm << 2);
            6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
            6'h03: begin npc = {pc4[31:28], ins[25:0], 2'b00}; we = 1'b1; dst = 5'd31; val = pc4; end
            default: ;
        endcase

        @(negedge inclk);
        inst         = ins;
        DM_rdata     = rdata;
        test_rf_addr = ($urandom() & 32'hFFFF_FFE0) | {27'd0, dst};
        #1;
        check_output("im_r", {31'd0, IM_R}, 32'd1);
        check_output("dm_ctrl", {29'd0, DM_CS, DM_R, DM_W}, {29'd0, cs, rstb, wstb});
        if (cs)      check_output("dm_addr", DM_addr, addr);
        if (wstb)    check_output("dm_wdata", DM_wdata, b);
        if (alu_chk) check_output("alu_out", ALU_out, val);
        check_output("pre_edge_rf", test_rf_data, m_rf[dst]);

        @(posedge inclk);
        #1;
        if (we && dst != 5'd0) m_rf[dst] = val;
        m_pc = npc;
        check_output("pc", PC, m_pc);
        check_output("post_edge_rf", test_rf_data, m_rf[dst]);
    endtask

    // Random legal (and occasionally unknown) instruction
    function automatic logic [31:0] rand_ins();
        logic [5:0] fns [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
        logic [5:0] ops [12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h23, 6'h2B, 6'h04, 6'h05};
        int k;
        k = int'($urandom_range(0, 9));
        if (k <= 4)
            return r_ins(fns[$urandom_range(0, 16)], int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 31)));
        else if (k <= 8)
            return i_ins(ops[$urandom_range(0, 11)], int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)));
        else begin
            case ($urandom_range(0, 3))
                0:       return j_ins(6'h02, int'($urandom_range(0, 32'h03FF_FFFF)));
                1:       return j_ins(6'h03, int'($urandom_range(0, 32'h03FF_FFFF)));
                2:       return {6'h3F, 26'($urandom())};
                default: return r_ins(6'h3F, 1, 2, 3, 0);
            endcase
        end
    endfunction

    initial begin
        inst         = 32'd0;
        DM_rdata     = 32'd0;
        test_rf_addr = 32'd0;
        model_reset();

        // Reset held, then released between edges
        #12;
        check_reset_state("reset");
        @(posedge inclk);
        #2;
        rstn = 1'b1;
        #1;
        check_output("pc_after_release", PC, 32'd0);

        // Arithmetic and compares
        apply_stimulus(i_ins(6'h08, 0, 1, 5), 32'd0);
        apply_stimulus(i_ins(6'h08, 0, 2, -7), 32'd0);
        apply_stimulus(r_ins(6'h20, 1, 2, 3, 0), 32'd0);
        check_reg("add_r3", 3, 32'hFFFF_FFFE);
        apply_stimulus(r_ins(6'h2A, 3, 1, 4, 0), 32'd0);
        check_reg("slt_r4", 4, 32'd1);
        apply_stimulus(r_ins(6'h2B, 3, 1, 5, 0), 32'd0);
        check_reg("sltu_r5", 5, 32'd0);

        // Memory access
        apply_stimulus(i_ins(6'h2B, 0, 3, 8), 32'hDEAD_BEEF);
        apply_stimulus(i_ins(6'h23, 0, 6, 4), 32'h0000_1234);
        check_reg("lw_r6", 6, 32'h0000_1234);

        // Control flow around PC=0x10
        apply_stimulus(j_ins(6'h02, 4), 32'd0);
        check_output("j_pc", PC, 32'h10);
        apply_stimulus(i_ins(6'h04, 1, 1, -2), 32'd0);
        check_output("beq_pc", PC, 32'h0C);
        apply_stimulus(j_ins(6'h02, 4), 32'd0);
        apply_stimulus(i_ins(6'h05, 1, 1, 7), 32'd0);
        check_output("bne_pc", PC, 32'h14);
        apply_stimulus(j_ins(6'h02, 4), 32'd0);
        apply_stimulus(j_ins(6'h03, 32'h40), 32'd0);
        check_output("jal_pc", PC, 32'h100);
        check_reg("jal_r31", 31, 32'h14);
        apply_stimulus(r_ins(6'h08, 31, 0, 0, 0), 32'd0);
        check_output("jr_pc", PC, 32'h14);

        // $0 and shifts
        apply_stimulus(i_ins(6'h08, 0, 0, 9), 32'd0);
        check_reg("r0_zero", 0, 32'd0);
        apply_stimulus(i_ins(6'h0F, 0, 7, 32'h8000), 32'd0);
        apply_stimulus(r_ins(6'h03, 0, 7, 8, 4), 32'd0);
        check_reg("sra_r8", 8, 32'hF800_0000);
        apply_stimulus(r_ins(6'h02, 0, 7, 9, 4), 32'd0);
        check_reg("srl_r9", 9, 32'h0800_0000);

        // Random program against the model
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(rand_ins(), $urandom());
        end

        // Asynchronous reset between edges mid-program
        @(posedge inclk);
        #3;
        rstn = 1'b0;
        #1;
        model_reset();
        check_reset_state("midreset");
        @(posedge inclk);
        #2;
        check_output("pc_held_in_reset", PC, 32'd0);
        rstn = 1'b1;
        apply_stimulus(i_ins(6'h08, 0, 1, 3), 32'd0);
        check_output("restart_pc", PC, 32'd4);
        check_reg("restart_r1", 1, 32'd3);
        for (int n = 0; n < 40; n++) begin
            apply_stimulus(rand_ins(), $urandom());
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
